noc_mux_rr: RTL
===============

Name: noc_mux_rr

Overview:
- Packet-level N:1 merger for the NoC flit interface; the counterpart of the per-class demux.
- Merges CHANNELS independent flit streams (one per class/virtual path) onto one output link.
- Round-robin arbitration between inputs; the grant is held from the first flit of a packet until its last flit, so packets never interleave.
- Sits in front of a router input port or link serializer.

Parameters:
- FLIT_WIDTH, 32, flit width in bits.
- CHANNELS, 7, number of input channels (2..8).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-low reset; 0 = reset.
- in_flit  input  CHANNELS x FLIT_WIDTH  per-channel flit (packed [CHANNELS-1:0][FLIT_WIDTH-1:0]).
- in_last  input  CHANNELS  per-channel last-flit marker.
- in_valid  input  CHANNELS  per-channel flit valid.
- in_ready  output  CHANNELS  per-channel ready; at most one bit set.
- out_flit  output  FLIT_WIDTH  merged flit.
- out_last  output  1  merged last marker.
- out_valid  output  1  merged valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Transfer rule: a beat transfers when valid and ready are both 1 in the same cycle. in_valid, in_flit and in_last must be held by the source until the beat transfers.
- State:
  - active: CHANNELS-bit one-hot grant register; 0 = IDLE.
  - prio: CHANNELS-bit one-hot round-robin pointer.
  - Reset (rst=0): active=0, prio=1 (channel 0 highest).
- Reset values of outputs:
  - out_valid=0 and in_ready=0 while rst=0.
  - out_flit and out_last are don't-care, but must drive channel 0's values.
- IDLE (active=0):
  - Combinational round-robin pick over in_valid: the first valid channel at or after prio, wrapping from CHANNELS-1 to 0.
  - out_valid = |in_valid. out_flit and out_last come from the picked channel. in_ready = pick & {CHANNELS{out_ready}}.
  - Zero-cycle latency from input to output.
- Next state from IDLE:
  - Transfer with out_last=1 (single-flit packet): active stays 0.
  - Transfer with out_last=0: active <= pick (LOCKED).
  - out_valid=1 but out_ready=0 (stalled offer): active <= pick, so the offered flit cannot be displaced by a higher-priority channel becoming valid.
- LOCKED (active!=0):
  - out_valid = |(active & in_valid). Output mux follows active. in_ready = active & {CHANNELS{out_ready}}.
  - Other channels see in_ready=0.
  - Transfer with out_last=1: active <= 0.
  - Gaps (active channel's in_valid=0) keep the lock.
- prio update: on every transfer whose out_last=1, prio <= grant rotated left by 1 (channel after the winner, wrapping). No other event changes prio.
- Simultaneous events: a last-flit transfer and a new request in the same cycle are handled by re-arbitration in the next cycle. There is a minimum of one cycle in IDLE between packets from different channels. The same channel re-arbitrates with lowest priority.
- Fairness: with all CHANNELS continuously requesting, packets are granted 0,1,...,CHANNELS-1,0,...
- Reset mid-packet: lock is dropped immediately and prio=1. The remaining flits of a partially sent packet are presented as a new packet after reset (upstream is reset together).
- Throughput: one flit per cycle within a packet.

Optional Feature:
- NOC_MUX_OUTREG_EN defined:
  - A 2-entry skid buffer is inserted on the output.
  - out_flit, out_last and out_valid are registered; in_ready is derived from buffer occupancy, not from out_ready.
  - Latency is 1 cycle, full throughput is preserved, and there is no combinational path from out_ready to in_ready.
  - The buffer is empty on reset. The arbitration and lock rules apply at the buffer input.
- Not defined: purely combinational output path as described above, 0 latency.

Test Plan:
- Single channel: ch2 sends a 3-flit packet (flits 0xA1,0xA2,0xA3, last on the 3rd) with out_ready=1 → out_flit sequence A1,A2,A3, out_last on the 3rd, in_ready=4'b0100 pattern throughout, active returns to 0.
- Contention: ch0 and ch1 each hold 2-flit packets from reset → ch0 packet is emitted fully, then ch1; no interleaving; prio=2'b10 after the first packet.
- Round-robin fairness: CHANNELS=4, all channels continuously offering single-flit packets → grant order 0,1,2,3,0,1 over 6 transfers.
- Backpressure/stall: ch3 offers a flit while out_ready=0 for 5 cycles; ch0 raises in_valid in cycle 2 → out_flit stays ch3's value, then ch3 transfers, then ch0.
- Gap in locked packet: ch1 sends flit 1, drops in_valid for 3 cycles while ch0 is valid → out_valid=0 during the gap, ch0 in_ready=0, lock held until ch1's last flit.
- Reset mid-packet: assert rst=0 after flit 2 of a 4-flit packet → next cycle active=0, out_valid=0, prio=1; with NOC_MUX_OUTREG_EN defined, the buffer is empty and the first output appears 1 cycle after the first post-reset offer.

Source files
------------

// File: rtl/noc_mux_rr_if.sv
// noc_mux_rr_if: flit bus bundle for the N:1 round-robin packet merger.
// Carries the per-channel input side and the merged output side.
// The master modport drives the sources and sinks the output; slave is the mux.
interface noc_mux_rr_if #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned CHANNELS   = 7
);
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [CHANNELS-1:0]                 in_last;
  logic [CHANNELS-1:0]                 in_valid;
  logic [CHANNELS-1:0]                 in_ready;
  logic [FLIT_WIDTH-1:0]               out_flit;
  logic                                out_last;
  logic                                out_valid;
  logic                                out_ready;

  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid
  );

  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid
  );
endinterface

// File: rtl/noc_mux_rr.sv
// noc_mux_rr: packet-level N:1 flit merger with round-robin arbitration.
// The grant is locked from the first flit of a packet until its last flit,
// so packets never interleave. Reset is synchronous and active-low (rst=0).
// Optional macro NOC_MUX_OUTREG_EN inserts a 2-entry output skid buffer
// (1-cycle latency, no combinational out_ready -> in_ready path).
module noc_mux_rr #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned CHANNELS   = 7
) (
  input  logic        clk,
  input  logic        rst,
  noc_mux_rr_if.slave noc
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef struct packed {
    logic                  last;
    logic [FLIT_WIDTH-1:0] flit;
  } beat_t;

  logic [CHANNELS-1:0] active_q, active_d;
  logic [CHANNELS-1:0] prio_q, prio_d;
  logic [CHANNELS-1:0] pick;
  logic [CHANNELS-1:0] grant;
  logic [IDX_W-1:0]    prio_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    scan_idx;
  int unsigned         scan_c;
  logic                found;
  logic                arb_valid;
  logic                arb_ready;
  logic                arb_xfer;
  beat_t               arb_beat;

  // Round-robin pick: first valid channel at or after the priority pointer.
  always_comb begin
    prio_idx = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (prio_q[i]) prio_idx = IDX_W'(i);
    end
    pick     = '0;
    found    = 1'b0;
    scan_c   = 0;
    scan_idx = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      scan_c = 32'(prio_idx) + i;
      if (scan_c >= CHANNELS) scan_c = scan_c - CHANNELS;
      scan_idx = IDX_W'(scan_c);
      if (!found && noc.in_valid[scan_idx]) begin
        pick[scan_idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  // Locked grant overrides the live pick; mux selects the granted channel.
  always_comb begin
    grant   = (active_q != '0) ? active_q : pick;
    sel_idx = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant[i]) sel_idx = IDX_W'(i);
    end
    if (!rst) sel_idx = '0;
    arb_beat.flit = noc.in_flit[sel_idx];
    arb_beat.last = noc.in_last[sel_idx];
    arb_valid     = rst & (|(grant & noc.in_valid));
    arb_xfer      = arb_valid & arb_ready;
  end

  assign noc.in_ready = grant & {CHANNELS{arb_ready}};

  // Lock on any offered non-final or stalled beat; release and rotate on last.
  always_comb begin
    active_d = active_q;
    prio_d   = prio_q;
    if (arb_xfer && arb_beat.last) begin
      active_d = '0;
      prio_d   = {grant[CHANNELS-2:0], grant[CHANNELS-1]};
    end else if (arb_valid) begin
      active_d = grant;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_q <= '0;
      prio_q   <= CHANNELS'(1);
    end else begin
      active_q <= active_d;
      prio_q   <= prio_d;
    end
  end

`ifdef NOC_MUX_OUTREG_EN
  beat_t      buf_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q, cnt_d;
  logic       pop;

  assign arb_ready     = rst & (cnt_q != 2'd2);
  assign noc.out_valid = rst & (cnt_q != 2'd0);
  assign noc.out_flit  = buf_q[rd_ptr_q].flit;
  assign noc.out_last  = buf_q[rd_ptr_q].last;
  assign pop           = noc.out_valid & noc.out_ready;
  assign cnt_d         = cnt_q + 2'(arb_xfer) - 2'(pop);

  // Skid buffer: push on arbitrated transfer, pop on downstream handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (arb_xfer) begin
        buf_q[wr_ptr_q] <= arb_beat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end
`else
  assign arb_ready     = rst & noc.out_ready;
  assign noc.out_valid = arb_valid;
  assign noc.out_flit  = arb_beat.flit;
  assign noc.out_last  = arb_beat.last;
`endif

endmodule
